// File: rtl/char_motion_ctrl_if.sv
// Button, collision and sprite-state bundle for one character.
// master: game logic side; slave: motion controller.
interface char_motion_ctrl_if;
  logic       vsync;
  logic       btn_left;
  logic       btn_right;
  logic       btn_jump;
  logic       blocked_left;
  logic       blocked_right;
  logic       blocked_up;
  logic       on_ground;
  logic       freeze;
  logic [9:0] img_x;
  logic [9:0] img_y;
  logic [2:0] frame_idx;
  logic       is_moving;
  logic       face_left;
  logic       in_air;
  logic       frame_tick;

  modport master (
    output vsync, btn_left, btn_right, btn_jump,
    output blocked_left, blocked_right, blocked_up,
    output on_ground, freeze,
    input  img_x, img_y, frame_idx, is_moving,
    input  face_left, in_air, frame_tick
  );

  modport slave (
    input  vsync, btn_left, btn_right, btn_jump,
    input  blocked_left, blocked_right, blocked_up,
    input  on_ground, freeze,
    output img_x, img_y, frame_idx, is_moving,
    output face_left, in_air, frame_tick
  );
endinterface

// File: rtl/char_motion_ctrl.sv
// Per-character motion and animation controller.
// Walks, jumps and animates once per video frame (vsync tick).
module char_motion_ctrl #(
  parameter int X_INIT      = 32,
  parameter int Y_INIT      = 320,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 608,
  parameter int Y_MAX       = 448,
  parameter int WALK_SPEED  = 2,
  parameter int JUMP_V      = 8,
  parameter int GRAVITY     = 1,
  parameter int MAX_FALL    = 8,
  parameter int ANIM_DIV    = 6,
  parameter int IDLE_FRAMES = 4,
  parameter int WALK_FRAMES = 6
) (
  input logic clk,
  input logic rst_n,
  char_motion_ctrl_if.slave bus
);

  localparam logic [0:0] GROUND = 1'b0;
  localparam logic [0:0] AIR    = 1'b1;

  localparam logic signed [10:0] XMIN_S = 11'(X_MIN);
  localparam logic signed [10:0] XMAX_S = 11'(X_MAX);
  localparam logic signed [10:0] YMAX_S = 11'(Y_MAX);
  localparam logic signed [10:0] WS_S   = 11'(WALK_SPEED);
  localparam logic signed [10:0] JV_S   = 11'(JUMP_V);
  localparam logic signed [10:0] HALF_T = 11'sd16;
  localparam logic signed [5:0]  VJ0    = 6'(GRAVITY - JUMP_V);
  localparam logic signed [5:0]  VG6    = 6'(GRAVITY);
  localparam logic signed [6:0]  VG7    = 7'(GRAVITY);
  localparam logic signed [6:0]  VMAX7  = 7'(MAX_FALL);
  localparam logic [3:0] AD_LAST = 4'(ANIM_DIV - 1);
  localparam logic [2:0] WF_LAST = 3'(WALK_FRAMES - 1);
  localparam logic [2:0] IF_LAST = 3'(IDLE_FRAMES - 1);

  logic s1, s2, s3, tick;

  logic [9:0]        x, y, x_n, y_n;
  logic signed [5:0] vy, vy_n;
  logic [0:0]        state, st_n;
  logic              armed, armed_n;
  logic              face, face_n;
  logic              mov, mov_n;
  logic [3:0]        cnt, cnt_n;
  logic [2:0]        frame, frame_n, lim;

  logic              dir_l, dir_r;
  logic signed [10:0] xs, ye, ys, yl;
  logic signed [5:0]  vb, vc;
  logic signed [6:0]  vg;

  // vsync is asynchronous: two sync flops, then an edge flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.vsync;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick = s2 & ~s3;

  always_comb begin
    dir_l  = bus.btn_left & ~bus.btn_right;
    dir_r  = bus.btn_right & ~bus.btn_left;
    mov_n  = (dir_l & ~bus.blocked_left)
           | (dir_r & ~bus.blocked_right);
    face_n = face;
    if (dir_l)
      face_n = 1'b1;
    else if (dir_r)
      face_n = 1'b0;
    xs = {1'b0, x};
    if (mov_n & dir_r)
      xs = xs + WS_S;
    else if (mov_n)
      xs = xs - WS_S;
    if (xs < XMIN_S)
      xs = XMIN_S;
    else if (xs > XMAX_S)
      xs = XMAX_S;
    x_n = xs[9:0];
  end

  always_comb begin
    y_n     = y;
    vy_n    = vy;
    st_n    = state;
    armed_n = armed;
    ye      = {1'b0, y};
    ys      = ye;
    yl      = ye + HALF_T;
    vb      = vy;
    vc      = vy;
    vg      = '0;
    unique case (1'b1)
      (state == GROUND): begin
        if (bus.btn_jump & armed & ~bus.blocked_up) begin
          ys = ye - JV_S;
          if (ys[10])
            ys = '0;
          y_n     = ys[9:0];
          vy_n    = VJ0;
          armed_n = 1'b0;
          st_n    = AIR;
        end else if (!bus.on_ground) begin
          vy_n = VG6;
          st_n = AIR;
        end
      end
      (state == AIR): begin
        if (bus.blocked_up && vy[5])
          vb = '0;
        if (!vb[5] && bus.on_ground) begin
          // snap feet to the nearest 32-pixel tile row
          st_n = GROUND;
          vy_n = '0;
          y_n  = {yl[9:5], 5'd0};
        end else begin
          ys = ye + {{5{vb[5]}}, vb};
          vc = vb;
          if (ys[10]) begin
            ys = '0;
            vc = '0;
          end
          vg = {vc[5], vc} + VG7;
          if (vg > VMAX7)
            vg = VMAX7;
          if (ys > YMAX_S) begin
            y_n  = YMAX_S[9:0];
            vy_n = '0;
            st_n = GROUND;
          end else begin
            y_n  = ys[9:0];
            vy_n = vg[5:0];
          end
        end
      end
      default: ;
    endcase
    if (!bus.btn_jump)
      armed_n = 1'b1;
  end

  always_comb begin
    lim     = mov_n ? WF_LAST : IF_LAST;
    cnt_n   = cnt;
    frame_n = frame;
    if (mov_n != mov) begin
      cnt_n   = '0;
      frame_n = '0;
    end else if (cnt == AD_LAST) begin
      cnt_n   = '0;
      frame_n = (frame >= lim) ? 3'd0 : frame + 3'd1;
    end else begin
      cnt_n = cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x     <= 10'(X_INIT);
      y     <= 10'(Y_INIT);
      vy    <= '0;
      state <= GROUND;
      armed <= 1'b1;
      face  <= 1'b0;
      mov   <= 1'b0;
      cnt   <= '0;
      frame <= '0;
    end else if (tick & ~bus.freeze) begin
      x     <= x_n;
      y     <= y_n;
      vy    <= vy_n;
      state <= st_n;
      armed <= armed_n;
      face  <= face_n;
      mov   <= mov_n;
      cnt   <= cnt_n;
      frame <= frame_n;
    end
  end

  assign bus.img_x      = x;
  assign bus.img_y      = y;
  assign bus.frame_idx  = frame;
  assign bus.is_moving  = mov;
  assign bus.face_left  = face;
  assign bus.in_air     = (state == AIR);
  assign bus.frame_tick = tick;

endmodule
